// File: rtl/regfile_write_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : regfile_write_ctrl
// Brief    : Register-file write-port controller. Runs a clear sweep after
//            reset, then arbitrates ALU and load writes and tracks pending
//            destination registers.
// Revision : 1.0
// ============================================================================
module regfile_write_ctrl #(
   parameter int DATA_W         = 32,
   parameter int ADDR_W         = 5,
   parameter int CLEAR_ON_RESET = 1
) (
   input  logic                     clk,
   input  logic                     rstd,
   input  logic                     alu_valid,
   output logic                     alu_ready,
   input  logic [ADDR_W-1:0]        alu_addr,
   input  logic [DATA_W-1:0]        alu_data,
   input  logic                     ld_valid,
   output logic                     ld_ready,
   input  logic [ADDR_W-1:0]        ld_addr,
   input  logic [DATA_W-1:0]        ld_data,
   input  logic                     issue_en,
   input  logic [ADDR_W-1:0]        issue_addr,
   output logic [(2**ADDR_W)-1:0]   pending,
   output logic                     rf_we,
   output logic [ADDR_W-1:0]        rf_waddr,
   output logic [DATA_W-1:0]        rf_wdata,
   output logic                     init_done
);

   localparam int NREG = 2**ADDR_W;

   typedef enum logic [0:0] {
      S_CLEAR = 1'b0,
      S_RUN   = 1'b1
   } state_t;

   localparam state_t            c_RESET_STATE = (CLEAR_ON_RESET != 0) ? S_CLEAR : S_RUN;
   localparam logic              c_RESET_INIT  = (CLEAR_ON_RESET != 0) ? 1'b0 : 1'b1;
   localparam logic              c_GRANT_ALU   = 1'b0;
   localparam logic              c_GRANT_LD    = 1'b1;
   localparam logic [ADDR_W-1:0] c_LAST_REG    = '1;
   localparam logic [ADDR_W-1:0] c_ZERO_REG    = '0;

   state_t              r_state;
   logic [ADDR_W-1:0]   r_clrCnt;
   logic                r_rrLast;
   logic [NREG-1:0]     r_pending;

   state_t              w_stateNext;
   logic [ADDR_W-1:0]   w_clrCntNext;
   logic                w_rrLastNext;
   logic                w_weNext;
   logic [ADDR_W-1:0]   w_waddrNext;
   logic [DATA_W-1:0]   w_wdataNext;
   logic                w_initNext;
   logic                w_accHit;
   logic [ADDR_W-1:0]   w_accAddr;
   logic                w_setHit;
   logic [NREG-1:0]     w_pendNext;

   // Next-state, grant and write-port decode
   always_comb begin
      w_stateNext  = r_state;
      w_clrCntNext = r_clrCnt;
      w_rrLastNext = r_rrLast;
      w_weNext     = 1'b0;
      w_waddrNext  = rf_waddr;
      w_wdataNext  = rf_wdata;
      w_initNext   = init_done;
      alu_ready    = 1'b0;
      ld_ready     = 1'b0;

      case (r_state)
         S_CLEAR: begin
            w_weNext     = 1'b1;
            w_waddrNext  = r_clrCnt;
            w_wdataNext  = '0;
            w_clrCntNext = r_clrCnt + ADDR_W'(1);
            if (r_clrCnt == c_LAST_REG) begin
               w_stateNext = S_RUN;
               w_initNext  = 1'b1;
            end
         end
         S_RUN: begin
            // On a tie, whichever side was not granted last wins
            if (alu_valid && ld_valid) begin
               alu_ready = (r_rrLast == c_GRANT_LD);
               ld_ready  = (r_rrLast == c_GRANT_ALU);
            end else begin
               alu_ready = alu_valid;
               ld_ready  = ld_valid;
            end

            if (alu_ready) begin
               w_rrLastNext = c_GRANT_ALU;
               if (alu_addr != c_ZERO_REG) begin
                  w_weNext    = 1'b1;
                  w_waddrNext = alu_addr;
                  w_wdataNext = alu_data;
               end
            end else if (ld_ready) begin
               w_rrLastNext = c_GRANT_LD;
               if (ld_addr != c_ZERO_REG) begin
                  w_weNext    = 1'b1;
                  w_waddrNext = ld_addr;
                  w_wdataNext = ld_data;
               end
            end
         end
         default: begin
            w_stateNext = c_RESET_STATE;
         end
      endcase
   end

   assign w_accHit  = alu_ready | ld_ready;
   assign w_accAddr = alu_ready ? alu_addr : ld_addr;
   assign w_setHit  = (r_state == S_RUN) && issue_en && (issue_addr != c_ZERO_REG);

   // Scoreboard: a same-cycle issue outranks the retiring write
   for (genvar i = 0; i < NREG; i++) begin : g_sb
      if (i == 0) begin : g_r0
         assign w_pendNext[i] = 1'b0;
      end else begin : g_rn
         localparam logic [ADDR_W-1:0] c_IDX = ADDR_W'(i);
         assign w_pendNext[i] = (w_setHit && (issue_addr == c_IDX)) ||
                                (r_pending[i] && !(w_accHit && (w_accAddr == c_IDX)));
      end
   end

   always_ff @(posedge clk or negedge rstd) begin
      if (!rstd) begin
         r_state   <= c_RESET_STATE;
         r_clrCnt  <= '0;
         r_rrLast  <= c_GRANT_LD;
         r_pending <= '0;
         rf_we     <= 1'b0;
         rf_waddr  <= '0;
         rf_wdata  <= '0;
         init_done <= c_RESET_INIT;
      end else begin
         r_state   <= w_stateNext;
         r_clrCnt  <= w_clrCntNext;
         r_rrLast  <= w_rrLastNext;
         r_pending <= w_pendNext;
         rf_we     <= w_weNext;
         rf_waddr  <= w_waddrNext;
         rf_wdata  <= w_wdataNext;
         init_done <= w_initNext;
      end
   end

   assign pending = r_pending;

endmodule
`default_nettype wire

// File: tb/tb_regfile_write_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_regfile_write_ctrl
// Brief    : Directed bench with a reference model of the write controller.
// Revision : 1.0
// ============================================================================
module tb_regfile_write_ctrl;

   logic        clk = 1'b0;
   logic        rstd = 1'b0;
   logic        alu_valid = 1'b0;
   logic        alu_ready;
   logic [4:0]  alu_addr = '0;
   logic [31:0] alu_data = '0;
   logic        ld_valid = 1'b0;
   logic        ld_ready;
   logic [4:0]  ld_addr = '0;
   logic [31:0] ld_data = '0;
   logic        issue_en = 1'b0;
   logic [4:0]  issue_addr = '0;
   logic [31:0] pending;
   logic        rf_we;
   logic [4:0]  rf_waddr;
   logic [31:0] rf_wdata;
   logic        init_done;

   int checks = 0;
   int errors = 0;

   regfile_write_ctrl #(.DATA_W(32), .ADDR_W(5), .CLEAR_ON_RESET(1)) dut (
      .clk(clk), .rstd(rstd),
      .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_addr(alu_addr), .alu_data(alu_data),
      .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_addr(ld_addr), .ld_data(ld_data),
      .issue_en(issue_en), .issue_addr(issue_addr), .pending(pending),
      .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .init_done(init_done)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h @%0t", nm, act, exp, $time);
      end
   endtask

   // Reference model: sweep counter, fairness flag, pending set, last write
   logic        mRun, mAluLast, mWe, mInit;
   int          mSweep;
   logic [4:0]  mAddr;
   logic [31:0] mData, mPend;

   function automatic logic modelAluGrant();
      return mRun && alu_valid && (!ld_valid || !mAluLast);
   endfunction
   function automatic logic modelLdGrant();
      return mRun && ld_valid && (!alu_valid || mAluLast);
   endfunction

   always @(posedge clk or negedge rstd) begin
      if (!rstd) begin
         mRun = 0; mAluLast = 0; mWe = 0; mInit = 0; mSweep = 0;
         mAddr = '0; mData = '0; mPend = '0;
      end else if (!mRun) begin
         mWe = 1; mAddr = 5'(mSweep); mData = 0;
         mSweep++;
         if (mSweep == 32) begin
            mRun = 1; mInit = 1;
         end
      end else begin
         logic ga, gl;
         ga = modelAluGrant();
         gl = modelLdGrant();
         mWe = 0;
         if (ga) begin
            mAluLast = 1;
            mPend[alu_addr] = 0;
            if (alu_addr != 0) begin mWe = 1; mAddr = alu_addr; mData = alu_data; end
         end else if (gl) begin
            mAluLast = 0;
            mPend[ld_addr] = 0;
            if (ld_addr != 0) begin mWe = 1; mAddr = ld_addr; mData = ld_data; end
         end
         if (issue_en && issue_addr != 0) mPend[issue_addr] = 1;
         mPend[0] = 0;
      end
   end

   always @(negedge clk) begin
      chk("model alu_ready", 64'(alu_ready), 64'(modelAluGrant()));
      chk("model ld_ready", 64'(ld_ready), 64'(modelLdGrant()));
      chk("model rf_we", 64'(rf_we), 64'(mWe));
      chk("model pending", 64'(pending), 64'(mPend));
      chk("model init_done", 64'(init_done), 64'(mInit));
      if (mWe) begin
         chk("model rf_waddr", 64'(rf_waddr), 64'(mAddr));
         chk("model rf_wdata", 64'(rf_wdata), 64'(mData));
      end
   end

   task automatic step();
      @(posedge clk); #1;
   endtask
   task automatic sample();
      @(negedge clk);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      int seq [4];
      int aluCnt, ldCnt;
      logic gAlu;
      seq = '{3, 7, 4, 8};

      // Reset state and the full clear sweep, with both requesters pushing
      repeat (2) @(posedge clk);
      #1;
      chk("reset rf_we", 64'(rf_we), 64'd0);
      chk("reset pending", 64'(pending), 64'd0);
      chk("reset init_done", 64'(init_done), 64'd0);
      rstd = 1'b1;
      alu_valid = 1; alu_addr = 5'd1; ld_valid = 1; ld_addr = 5'd2;
      @(posedge clk);
      for (int i = 0; i < 32; i++) begin
         sample();
         chk("sweep we", 64'(rf_we), 64'd1);
         chk("sweep addr", 64'(rf_waddr), 64'(i));
         chk("sweep data", 64'(rf_wdata), 64'd0);
         chk("sweep ready", 64'({alu_ready, ld_ready}), 64'd0);
         if (i == 30) begin
            chk("init before end", 64'(init_done), 64'd0);
            #1 alu_valid = 0; ld_valid = 0;
         end
      end
      chk("init after sweep", 64'(init_done), 64'd1);

      // Single ALU write
      step(); alu_valid = 1; alu_addr = 5'd5; alu_data = 32'hDEADBEEF;
      sample(); chk("alu only ready", 64'({alu_ready, ld_ready}), 64'b10);
      step(); alu_valid = 0;
      sample();
      chk("alu wr we", 64'(rf_we), 64'd1);
      chk("alu wr addr", 64'(rf_waddr), 64'd5);
      chk("alu wr data", 64'(rf_wdata), 64'hDEADBEEF);
      sample(); chk("idle we", 64'(rf_we), 64'd0);

      // Single load write, so the next tie goes to the ALU
      step(); ld_valid = 1; ld_addr = 5'd10; ld_data = 32'h1234;
      sample(); chk("ld only ready", 64'({alu_ready, ld_ready}), 64'b01);
      step(); ld_valid = 0;
      sample(); chk("ld wr addr", 64'(rf_waddr), 64'd10);

      // Round-robin on sustained contention
      step();
      alu_valid = 1; alu_addr = 5'd3; alu_data = 32'hA3;
      ld_valid = 1; ld_addr = 5'd7; ld_data = 32'hB7;
      aluCnt = 0; ldCnt = 0;
      for (int k = 0; k < 4; k++) begin
         sample();
         gAlu = alu_ready;
         chk("rr grant", 64'({alu_ready, ld_ready}), (k % 2 == 0) ? 64'b10 : 64'b01);
         if (k >= 1) begin
            chk("rr stream we", 64'(rf_we), 64'd1);
            chk("rr stream addr", 64'(rf_waddr), 64'(seq[k-1]));
         end
         step();
         if (gAlu) begin
            aluCnt++;
            if (aluCnt == 1) begin alu_addr = 5'd4; alu_data = 32'hA4; end
            else alu_valid = 0;
         end else begin
            ldCnt++;
            if (ldCnt == 1) begin ld_addr = 5'd8; ld_data = 32'hB8; end
            else ld_valid = 0;
         end
      end
      sample();
      chk("rr last we", 64'(rf_we), 64'd1);
      chk("rr last addr", 64'(rf_waddr), 64'(seq[3]));

      // Scoreboard: issue then retire three cycles later
      step(); issue_en = 1; issue_addr = 5'd9;
      step(); issue_en = 0;
      sample(); chk("pend9 c1", 64'(pending[9]), 64'd1);
      step();
      sample(); chk("pend9 c2", 64'(pending[9]), 64'd1);
      step(); ld_valid = 1; ld_addr = 5'd9; ld_data = 32'h99;
      sample();
      chk("pend9 c3", 64'(pending[9]), 64'd1);
      chk("pend9 ld ready", 64'(ld_ready), 64'd1);
      step(); ld_valid = 0;
      sample(); chk("pend9 cleared", 64'(pending[9]), 64'd0);

      // Same-cycle issue and retire: issue wins
      step(); issue_en = 1; issue_addr = 5'd9; ld_valid = 1; ld_addr = 5'd9; ld_data = 32'h9A;
      step(); issue_en = 0; ld_valid = 0;
      sample();
      chk("pend9 set wins", 64'(pending[9]), 64'd1);
      chk("pend9 wr addr", 64'(rf_waddr), 64'd9);

      // Writes and issues to r0
      step(); alu_valid = 1; alu_addr = 5'd0; alu_data = 32'hFFFFFFFF; issue_en = 1; issue_addr = 5'd0;
      sample(); chk("r0 ready", 64'(alu_ready), 64'd1);
      step(); alu_valid = 0; issue_en = 0;
      sample();
      chk("r0 no write", 64'(rf_we), 64'd0);
      chk("r0 pending", 64'(pending), 64'h200);

      // Reset in RUN with writes pending and one in flight
      step(); issue_en = 1; issue_addr = 5'd8;
      step(); issue_en = 0;
      sample(); chk("pend 300", 64'(pending), 64'h300);
      step(); alu_valid = 1; alu_addr = 5'd12; alu_data = 32'h5;
      step(); alu_valid = 0;
      chk("inflight we", 64'(rf_we), 64'd1);
      #1 rstd = 0;
      #1;
      chk("run rst we", 64'(rf_we), 64'd0);
      chk("run rst pending", 64'(pending), 64'd0);
      chk("run rst init", 64'(init_done), 64'd0);
      chk("run rst addr", 64'(rf_waddr), 64'd0);
      step(); rstd = 1;
      @(posedge clk);
      for (int i = 0; i < 17; i++) begin
         sample(); chk("resweep addr", 64'(rf_waddr), 64'(i));
      end

      // Reset again mid-sweep with clr_cnt at 17
      #1 rstd = 0;
      #1;
      chk("sweep rst we", 64'(rf_we), 64'd0);
      chk("sweep rst addr", 64'(rf_waddr), 64'd0);
      step(); rstd = 1;
      @(posedge clk);
      for (int i = 0; i < 32; i++) begin
         sample();
         chk("final sweep we", 64'(rf_we), 64'd1);
         chk("final sweep addr", 64'(rf_waddr), 64'(i));
      end
      chk("final init", 64'(init_done), 64'd1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
